// File: rtl/ufp_mem_responder_pkg.sv
// Shared types and helpers for the ufp memory responder.
// Defines the FSM state, the captured request record and the port owner tag.
package ufp_rsp_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [3:0]  rmask;
        logic [3:0]  wmask;
        logic [31:0] wdata;
    } ufp_req_t;

    typedef enum logic {
        OWN_IMEM,
        OWN_DMEM
    } owner_t;

    // A request is present whenever either mask is nonzero.
    function automatic logic req_pulse(ufp_req_t r);
        return (|r.rmask) || (|r.wmask);
    endfunction

    // Writes take precedence when both masks are set.
    function automatic logic req_is_write(ufp_req_t r);
        return |r.wmask;
    endfunction

    // Backing memory is word addressed; drop the byte offset.
    function automatic logic [31:0] word_addr(logic [31:0] a);
        return a & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/ufp_mem_responder_slot.sv
// Single pending-request slot for one core port (module ufp_req_slot).
// Captures a request pulse when empty, or when being freed on the same edge;
// pulses into an occupied slot are dropped.
module ufp_req_slot
    import ufp_rsp_pkg::*;
(
    input  logic     clk,
    input  logic     rst,
    input  ufp_req_t req,
    input  logic     free,
    output logic     full,
    output ufp_req_t held
);

    logic take;

    assign take = req_pulse(req) && (!full || free);

    // Occupancy flag: set on capture, cleared when the responder frees the slot.
    // NOTE: clocked state always uses non-blocking assignments so every flop
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk) begin
        if (rst) begin
            full <= 1'b0;
        end else if (take) begin
            full <= 1'b1;
        end else if (free) begin
            full <= 1'b0;
        end
    end

    // Request payload, loaded on capture.
    // NOTE: the payload carries no reset; it is only consumed while full is set,
    // and downstream outputs are gated by the FSM state.
    always_ff @(posedge clk) begin
        if (take) begin
            held <= req;
        end
    end

endmodule

// File: rtl/ufp_mem_responder.sv
// ufp_mem_responder: serialises the core's imem/dmem request pulses onto one
// single-outstanding word memory port and returns one-cycle response pulses.
// Build option: define UFP_RSP_RR_ARB_EN for round-robin arbitration
// (dmem wins the first tie); otherwise fixed priority selected by IMEM_FIRST.
module ufp_mem_responder
    import ufp_rsp_pkg::*;
#(
    parameter int unsigned WDT_W      = 10,
    parameter int unsigned IMEM_FIRST = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] imem_addr,
    input  logic [3:0]  imem_rmask,
    output logic [31:0] imem_rdata,
    output logic        imem_resp,
    input  logic [31:0] dmem_addr,
    input  logic [3:0]  dmem_rmask,
    input  logic [3:0]  dmem_wmask,
    input  logic [31:0] dmem_wdata,
    output logic [31:0] dmem_rdata,
    output logic        dmem_resp,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_wmask,
    output logic [31:0] mem_wdata,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        err_timeout
);

    // Watchdog fires on the wait cycle where the count would reach all-ones.
    localparam logic [WDT_W-1:0] WDT_LAST = {{(WDT_W-1){1'b1}}, 1'b0};

    state_t           state;
    state_t           state_next;
    owner_t           owner;
    owner_t           winner;
    logic [WDT_W-1:0] wdt;
    logic             timeout;

    ufp_req_t imem_req_in;
    ufp_req_t dmem_req_in;
    ufp_req_t imem_held;
    ufp_req_t dmem_held;
    ufp_req_t cur;
    logic     imem_full;
    logic     dmem_full;
    logic     any_full;

    assign imem_req_in = '{addr: imem_addr, rmask: imem_rmask, wmask: 4'h0, wdata: 32'h0};
    assign dmem_req_in = '{addr: dmem_addr, rmask: dmem_rmask, wmask: dmem_wmask, wdata: dmem_wdata};

    ufp_req_slot u_imem_slot (
        .clk  (clk),
        .rst  (rst),
        .req  (imem_req_in),
        .free (imem_resp),
        .full (imem_full),
        .held (imem_held)
    );

    ufp_req_slot u_dmem_slot (
        .clk  (clk),
        .rst  (rst),
        .req  (dmem_req_in),
        .free (dmem_resp),
        .full (dmem_full),
        .held (dmem_held)
    );

    assign any_full = imem_full || dmem_full;
    assign cur      = (owner == OWN_IMEM) ? imem_held : dmem_held;
    assign timeout  = (state == WAIT) && !mem_rvalid && (wdt == WDT_LAST);

`ifdef UFP_RSP_RR_ARB_EN
    owner_t last_served;

    // Round-robin pick: on a tie the port served most recently loses.
    always_comb begin
        if (imem_full && dmem_full) begin
            winner = (last_served == OWN_IMEM) ? OWN_DMEM : OWN_IMEM;
        end else if (imem_full) begin
            winner = OWN_IMEM;
        end else begin
            winner = OWN_DMEM;
        end
    end

    // Remember the last port chosen; starts as imem so dmem takes the first tie.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_served <= OWN_IMEM;
        end else if (state == IDLE && any_full) begin
            last_served <= winner;
        end
    end
`else
    localparam owner_t TIE_WINNER = (IMEM_FIRST != 0) ? OWN_IMEM : OWN_DMEM;

    // Fixed-priority pick: the preferred port always wins a tie.
    always_comb begin
        if (imem_full && dmem_full) begin
            winner = TIE_WINNER;
        end else if (imem_full) begin
            winner = OWN_IMEM;
        end else begin
            winner = OWN_DMEM;
        end
    end
`endif

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM next-state logic.
    // NOTE: the default assignment on entry keeps this block free of inferred latches.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:  if (any_full)              state_next = ISSUE;
            ISSUE: if (mem_gnt)               state_next = req_is_write(cur) ? RESP : WAIT;
            WAIT:  if (mem_rvalid || timeout) state_next = RESP;
            RESP:                             state_next = IDLE;
            default:                          state_next = IDLE;
        endcase
    end

    // FSM outputs: memory request while issuing, owner response pulse in RESP.
    always_comb begin
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wmask = '0;
        mem_wdata = '0;
        imem_resp = 1'b0;
        dmem_resp = 1'b0;
        if (state == ISSUE) begin
            mem_req   = 1'b1;
            mem_we    = req_is_write(cur);
            mem_addr  = word_addr(cur.addr);
            mem_wmask = req_is_write(cur) ? cur.wmask : cur.rmask;
            mem_wdata = cur.wdata;
        end
        if (state == RESP) begin
            imem_resp = (owner == OWN_IMEM);
            dmem_resp = (owner == OWN_DMEM);
        end
    end

    // Latch the arbitration winner as the owner of the next transaction.
    always_ff @(posedge clk) begin
        if (rst) begin
            owner <= OWN_IMEM;
        end else if (state == IDLE && any_full) begin
            owner <= winner;
        end
    end

    // Watchdog counts read-wait cycles and is zero whenever not waiting.
    always_ff @(posedge clk) begin
        if (rst) begin
            wdt <= '0;
        end else if (state == WAIT && state_next == WAIT) begin
            wdt <= wdt + 1'b1;
        end else begin
            wdt <= '0;
        end
    end

    // Sticky timeout flag, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_timeout <= 1'b0;
        end else if (timeout) begin
            err_timeout <= 1'b1;
        end
    end

    // Register read data into the owner's rdata as the read completes; zero on timeout.
    always_ff @(posedge clk) begin
        if (rst) begin
            imem_rdata <= '0;
            dmem_rdata <= '0;
        end else if (state == WAIT && (mem_rvalid || timeout)) begin
            if (owner == OWN_IMEM) begin
                imem_rdata <= mem_rvalid ? mem_rdata : 32'h0;
            end else begin
                dmem_rdata <= mem_rvalid ? mem_rdata : 32'h0;
            end
        end
    end

endmodule
